// File: rtl/bus_pkg.sv
// Shared bus constants: ID field width, broadcast address, and field/counter helpers.
package bus_pkg;

    localparam int unsigned ID_W     = 8;
    localparam logic [7:0]  BCAST_ID = 8'hFF;
    localparam int unsigned CNT_W    = 16;

    // Destination ID occupies the top ID_W bits of a packet of width w.
    function automatic int unsigned id_lsb(input int unsigned w);
        return w - ID_W;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a read frees a slot for a write on the same edge.
module sync_fifo #(
    parameter int unsigned width = 16,
    parameter int unsigned depth = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [width-1:0] wr_data,
    input  logic             rd,
    output logic [width-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd && !empty;
    assign do_wr   = wr && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_rd) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !reset) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/bus_dev_endpoint.sv
// Bus endpoint: TX FIFO toward the arbiter, address-filtered RX FIFO toward the user, status counters.
module bus_dev_endpoint
    import bus_pkg::*;
#(
    parameter int unsigned     pckg_sz = 16,
    parameter int unsigned     depth   = 8,
    parameter logic [ID_W-1:0] dev_id  = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_wr,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    input  logic               rx_rd,
    output logic [pckg_sz-1:0] rx_data,
    output logic               rx_empty,
    output logic               pndng,
    input  logic               pop,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    output logic               rx_ovf,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic [CNT_W-1:0]   misroute_cnt,
    output logic [CNT_W-1:0]   tx_cnt
);

    localparam int unsigned ID_LSB = id_lsb(pckg_sz);

    logic [ID_W-1:0] dest_id;
    logic            id_match;
    logic            rx_push;
    logic            rx_full;
    logic            tx_empty;
    logic            rx_drop;

    assign dest_id  = D_push[ID_LSB +: ID_W];
    assign id_match = (dest_id == dev_id) || (dest_id == BCAST_ID);
    assign rx_push  = push && id_match;
    assign pndng    = !tx_empty;
    // A same-edge read makes room, so only an unaccompanied push into a full FIFO is lost.
    assign rx_drop  = rx_push && rx_full && !rx_rd;

    sync_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr      (tx_wr),
        .wr_data (tx_data),
        .rd      (pop),
        .rd_data (D_pop),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    sync_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr      (rx_push),
        .wr_data (D_push),
        .rd      (rx_rd),
        .rd_data (rx_data),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_ovf       <= 1'b0;
            drop_cnt     <= '0;
            misroute_cnt <= '0;
            tx_cnt       <= '0;
        end else begin
            if (push && !id_match) misroute_cnt <= sat_inc(misroute_cnt);
            if (rx_drop) begin
                rx_ovf   <= 1'b1;
                drop_cnt <= sat_inc(drop_cnt);
            end
            if (pop && !tx_empty) tx_cnt <= sat_inc(tx_cnt);
        end
    end

endmodule

// File: tb/tb_bus_dev_endpoint.sv
// Directed bench for bus_dev_endpoint (dev_id=3, 16-bit packets, depth 8).
module tb_bus_dev_endpoint;
    import bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset, tx_wr, rx_rd, pop, push;
    logic [15:0] tx_data, D_push;
    logic        tx_full, rx_empty, pndng, rx_ovf;
    logic [15:0] rx_data, D_pop, drop_cnt, misroute_cnt, tx_cnt;

    int vectors = 0;
    int errs    = 0;

    logic [15:0] ref_q [$];
    int          ref_cnt;

    bus_dev_endpoint #(.pckg_sz(16), .depth(8), .dev_id(8'd3)) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_wr        (tx_wr),
        .tx_data      (tx_data),
        .tx_full      (tx_full),
        .rx_rd        (rx_rd),
        .rx_data      (rx_data),
        .rx_empty     (rx_empty),
        .pndng        (pndng),
        .pop          (pop),
        .D_pop        (D_pop),
        .push         (push),
        .D_push       (D_push),
        .rx_ovf       (rx_ovf),
        .drop_cnt     (drop_cnt),
        .misroute_cnt (misroute_cnt),
        .tx_cnt       (tx_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        tx_wr = 0; rx_rd = 0; pop = 0; push = 0;
    endtask

    initial begin
        reset = 1; idle(); tx_data = '0; D_push = '0;
        step(); step();
        reset = 0;
        chk("rst_pndng", pndng, 0);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_rx_empty", rx_empty, 1);
        chk("rst_D_pop", D_pop, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_cnts", {rx_ovf, drop_cnt, misroute_cnt, tx_cnt}, 0);

        // TX basic
        tx_wr = 1; tx_data = 16'h0312; step();
        tx_data = 16'h0345; step();
        tx_wr = 0;
        chk("tx_pndng", pndng, 1);
        chk("tx_head0", D_pop, 16'h0312);
        pop = 1; step(); pop = 0;
        chk("tx_head1", D_pop, 16'h0345);
        pop = 1; step(); pop = 0;
        chk("tx_pndng_empty", pndng, 0);
        chk("tx_D_pop_zero", D_pop, 0);
        chk("tx_cnt2", tx_cnt, 2);
        pop = 1; step(); pop = 0;
        chk("pop_empty_cnt", tx_cnt, 2);
        chk("pop_empty_pndng", pndng, 0);

        // RX filtering
        push = 1; D_push = 16'h0311; step();
        D_push = 16'hFF22; step();
        push = 0;
        chk("rx_head0", rx_data, 16'h0311);
        rx_rd = 1; step(); rx_rd = 0;
        chk("rx_head1", rx_data, 16'hFF22);
        rx_rd = 1; step(); rx_rd = 0;
        chk("rx_empty_after", rx_empty, 1);
        chk("rx_data_zero", rx_data, 0);
        push = 1; D_push = 16'h0533; step(); push = 0;
        chk("misroute1", misroute_cnt, 1);
        chk("misroute_rx_empty", rx_empty, 1);
        rx_rd = 1; step(); rx_rd = 0;
        chk("rd_empty_ignored", {rx_empty, rx_data}, {1'b1, 16'h0000});

        // RX overflow
        push = 1;
        for (int i = 0; i < 8; i++) begin
            D_push = 16'h03A0 + 16'(i); step();
        end
        D_push = 16'h0399; step();
        push = 0;
        chk("ovf_flag", rx_ovf, 1);
        chk("drop1", drop_cnt, 1);
        chk("ovf_head", rx_data, 16'h03A0);
        push = 1; rx_rd = 1; D_push = 16'hFF55; step();
        push = 0; rx_rd = 0;
        chk("full_push_rd_drop", drop_cnt, 1);
        chk("full_push_rd_head", rx_data, 16'h03A1);
        for (int i = 1; i < 9; i++) begin
            chk("rx_drain", rx_data, (i < 8) ? 16'h03A0 + 16'(i) : 16'hFF55);
            rx_rd = 1; step(); rx_rd = 0;
        end
        chk("rx_drained", rx_empty, 1);

        // TX full with simultaneous write and pop
        tx_wr = 1;
        for (int i = 0; i < 8; i++) begin
            tx_data = 16'h0100 + 16'(i); step();
        end
        chk("tx_full8", tx_full, 1);
        pop = 1; tx_data = 16'h01EE; step(); pop = 0;
        chk("tx_full_wrpop", tx_full, 1);
        chk("tx_full_wrpop_head", D_pop, 16'h0101);
        tx_data = 16'h01FF; step(); tx_wr = 0;
        chk("tx_wr_full_ignored", tx_cnt, 3);
        for (int i = 1; i < 9; i++) begin
            chk("tx_drain", D_pop, (i < 8) ? 16'h0100 + 16'(i) : 16'h01EE);
            pop = 1; step(); pop = 0;
        end
        chk("tx_drained", pndng, 0);
        chk("tx_cnt11", tx_cnt, 11);

        // One-entry write+pop
        tx_wr = 1; tx_data = 16'h0AAA; step();
        pop = 1; tx_data = 16'h0BBB; step();
        tx_wr = 0; pop = 0;
        chk("one_wrpop_pndng", pndng, 1);
        chk("one_wrpop_head", D_pop, 16'h0BBB);
        pop = 1; step(); pop = 0;
        chk("one_wrpop_cnt", tx_cnt, 13);

        // Reset mid-operation
        tx_wr = 1;
        for (int i = 0; i < 5; i++) begin
            tx_data = 16'h0C00 + 16'(i); step();
        end
        push = 1; D_push = 16'h0377; step(); push = 0;
        reset = 1; push = 1; pop = 1; tx_wr = 1; D_push = 16'h0388; tx_data = 16'h0DDD;
        step();
        reset = 0; idle();
        chk("mid_rst_pndng", pndng, 0);
        chk("mid_rst_full", tx_full, 0);
        chk("mid_rst_rx_empty", rx_empty, 1);
        chk("mid_rst_data", {D_pop, rx_data}, 0);
        chk("mid_rst_cnts", {rx_ovf, drop_cnt, misroute_cnt, tx_cnt}, 0);

        // Randomised TX traffic against a reference queue
        ref_q.delete();
        ref_cnt = 0;
        for (int c = 0; c < 24; c++) begin
            logic w, p, p_ok, w_ok;
            logic [15:0] d;
            chk("rnd_pndng", pndng, ref_q.size() != 0);
            chk("rnd_head", D_pop, (ref_q.size() != 0) ? ref_q[0] : 16'h0000);
            w = ($urandom_range(3) != 0);
            p = ($urandom_range(1) != 0);
            d = 16'($urandom);
            p_ok = p && (ref_q.size() != 0);
            w_ok = w && ((ref_q.size() < 8) || p_ok);
            tx_wr = w; pop = p; tx_data = d;
            step();
            idle();
            if (p_ok) begin
                void'(ref_q.pop_front());
                ref_cnt++;
            end
            if (w_ok) ref_q.push_back(d);
            chk("rnd_full", tx_full, ref_q.size() == 8);
        end
        chk("rnd_tx_cnt", tx_cnt, ref_cnt);
        while (ref_q.size() != 0) begin
            chk("rnd_drain", D_pop, ref_q.pop_front());
            pop = 1; step(); pop = 0;
        end
        chk("rnd_end_pndng", pndng, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
